reset_manager: RTL and testbench

Reset sequencer that sits directly after `clock_manager` and consumes its MMCM `locked` status. It synchronises `locked`, holds the design in reset until the clock has been stable for a programmable number of cycles, and then releases a synchronously deasserted reset. It re-enters reset on loss of lock or on a software request, and keeps a saturating count of lock-loss events for debug.

---
 rtl/clk_rst_pkg.sv | 19 +
 rtl/sync_ff.sv | 30 +++
 rtl/reset_manager.sv | 112 +++++++++++
 tb/tb_reset_manager.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_rst_pkg.sv
// Shared clock/reset definitions: reset sequencer state encodings and parameter defaults.
package clk_rst_pkg;

   localparam int DEF_SYNC_STAGES = 2;
   localparam int DEF_HOLD_CYCLES = 1024;

   localparam logic [1:0] ST_WAIT_LOCK = 2'd0;
   localparam logic [1:0] ST_HOLD      = 2'd1;
   localparam logic [1:0] ST_RUN       = 2'd2;
   localparam logic [1:0] ST_UNUSED    = 2'd3;

   typedef enum logic [1:0] {
      WAIT_LOCK = ST_WAIT_LOCK,
      HOLD      = ST_HOLD,
      RUN       = ST_RUN,
      UNUSED    = ST_UNUSED
   } rst_state_e;

endpackage

// File: rtl/sync_ff.sv
// Single-bit multi-stage synchroniser with asynchronous active-low clear.
module sync_ff #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic dout
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;

   // Shift the asynchronous input one stage further each cycle.
   always_comb begin
      sync_d = {sync_q[STAGES-2:0], din};
   end

   // Synchroniser chain, cleared to zero so a reset reads as "not locked".
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign dout = sync_q[STAGES-1];

endmodule

// File: rtl/reset_manager.sv
// Reset sequencer: waits for a stable MMCM lock, holds reset for a programmable
// number of cycles, then releases a synchronously deasserted reset.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   WAIT_LOCK | clock not locked, design held in reset
//   HOLD      | lock seen, counting stable cycles before release
//   RUN       | reset released, oready high
//   UNUSED    | illegal encoding, falls back to WAIT_LOCK
module reset_manager
   import clk_rst_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
   parameter int CNT_W       = 8
) (
   input  logic             iclk_100MHz,
   input  logic             irst_n,
   input  logic             ilocked,
   input  logic             ireq_soft,
   output logic             orst_n,
   output logic             orst,
   output logic             oready,
   output logic [1:0]       ostate,
   output logic [CNT_W-1:0] olock_lost_cnt
);

   localparam int                HCNT_W    = $clog2(HOLD_CYCLES + 1);
   localparam logic [HCNT_W-1:0] HOLD_LAST = HCNT_W'(HOLD_CYCLES - 1);

   logic              locked_s;
   rst_state_e        state_q,    state_d;
   logic [HCNT_W-1:0] hold_cnt_q, hold_cnt_d;
   logic [CNT_W-1:0]  lost_cnt_q, lost_cnt_d;
   logic              rst_n_q,    rst_n_d;
   logic              ready_q,    ready_d;

   sync_ff #(
      .STAGES (SYNC_STAGES)
   ) u_lock_sync (
      .clk   (iclk_100MHz),
      .rst_n (irst_n),
      .din   (ilocked),
      .dout  (locked_s)
   );

   // Next state, hold timer and lock-loss counter; lock loss always wins over a soft request.
   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      lost_cnt_d = lost_cnt_q;
      case (state_q)
         WAIT_LOCK: begin
            if (locked_s) begin
               state_d    = HOLD;
               hold_cnt_d = '0;
            end
         end
         HOLD: begin
            if (!locked_s) begin
               state_d = WAIT_LOCK;
            end else if (ireq_soft) begin
               hold_cnt_d = '0;
            end else if (hold_cnt_q == HOLD_LAST) begin
               state_d = RUN;
            end else begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
         end
         RUN: begin
            if (!locked_s) begin
               state_d = WAIT_LOCK;
               if (lost_cnt_q != '1) begin
                  lost_cnt_d = lost_cnt_q + 1'b1;
               end
            end else if (ireq_soft) begin
               state_d    = HOLD;
               hold_cnt_d = '0;
            end
         end
         default: begin
            state_d = WAIT_LOCK;
         end
      endcase
      rst_n_d = (state_d == RUN);
      ready_d = (state_d == RUN);
   end

   // State and output registers; outputs follow the next state so they switch with it.
   always_ff @(posedge iclk_100MHz or negedge irst_n) begin
      if (!irst_n) begin
         state_q    <= WAIT_LOCK;
         hold_cnt_q <= '0;
         lost_cnt_q <= '0;
         rst_n_q    <= 1'b0;
         ready_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         hold_cnt_q <= hold_cnt_d;
         lost_cnt_q <= lost_cnt_d;
         rst_n_q    <= rst_n_d;
         ready_q    <= ready_d;
      end
   end

   assign orst_n         = rst_n_q;
   assign orst           = ~rst_n_q;
   assign oready         = ready_q;
   assign ostate         = state_q;
   assign olock_lost_cnt = lost_cnt_q;

endmodule

// File: tb/tb_reset_manager.sv
// Bench for reset_manager: directed scenarios plus random lock/soft-request traffic,
// checked against a window-based reference model through an expectation queue.
module tb_reset_manager;

   localparam int S = 2;
   localparam int H = 16;
   localparam int W = 4;
   localparam int SAT = (1 << W) - 1;

   typedef struct {
      logic       rst_n;
      logic       ready;
      logic [1:0] state;
      logic [W-1:0] cnt;
   } exp_t;

   logic         clk;
   logic         irst_n;
   logic         ilocked;
   logic         ireq_soft;
   logic         orst_n;
   logic         orst;
   logic         oready;
   logic [1:0]   ostate;
   logic [W-1:0] olock_lost_cnt;

   int checks = 0;
   int errors = 0;

   exp_t exp_q[$];

   bit lk_h[$];
   bit ls_h[$];
   bit sf_h[$];
   bit run_prev;
   int lost_exp;

   reset_manager #(
      .SYNC_STAGES (S),
      .HOLD_CYCLES (H),
      .CNT_W       (W)
   ) dut (
      .iclk_100MHz    (clk),
      .irst_n         (irst_n),
      .ilocked        (ilocked),
      .ireq_soft      (ireq_soft),
      .orst_n         (orst_n),
      .orst           (orst),
      .oready         (oready),
      .ostate         (ostate),
      .olock_lost_cnt (olock_lost_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: the design is in RUN exactly when the synchronised lock has
   // been high on the last H+1 edges and no soft request arrived on the last H edges.
   // Outside RUN it is in HOLD if the lock seen on this edge is high, else WAIT_LOCK.
   always @(posedge clk) begin
      exp_t e;
      int   n;
      bit   run;
      if (!irst_n) begin
         lk_h.delete();
         ls_h.delete();
         sf_h.delete();
         run_prev = 1'b0;
         lost_exp = 0;
         e.rst_n = 1'b0; e.ready = 1'b0; e.state = 2'd0; e.cnt = '0;
         exp_q.push_back(e);
      end else begin
         lk_h.push_back(ilocked);
         sf_h.push_back(ireq_soft);
         n = lk_h.size() - 1;
         ls_h.push_back((n >= S) ? lk_h[n-S] : 1'b0);
         run = 1'b0;
         if (n >= H) begin
            run = 1'b1;
            for (int k = n - H; k <= n; k++) if (!ls_h[k]) run = 1'b0;
            for (int k = n - H + 1; k <= n; k++) if (sf_h[k]) run = 1'b0;
         end
         if (!ls_h[n] && run_prev && lost_exp < SAT) lost_exp++;
         e.rst_n = run;
         e.ready = run;
         e.state = run ? 2'd2 : (ls_h[n] ? 2'd1 : 2'd0);
         e.cnt   = W'(lost_exp);
         exp_q.push_back(e);
         run_prev = run;
      end
   end

   // Monitor: one expectation per edge, compared away from the active edge.
   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (orst_n !== e.rst_n) begin
            errors++;
            $display("FAIL orst_n t=%0t got %b want %b", $time, orst_n, e.rst_n);
         end
         checks++;
         if (orst !== ~e.rst_n) begin
            errors++;
            $display("FAIL orst t=%0t got %b want %b", $time, orst, ~e.rst_n);
         end
         checks++;
         if (oready !== e.ready) begin
            errors++;
            $display("FAIL oready t=%0t got %b want %b", $time, oready, e.ready);
         end
         checks++;
         if (ostate !== e.state) begin
            errors++;
            $display("FAIL ostate t=%0t got %0d want %0d", $time, ostate, e.state);
         end
         checks++;
         if (olock_lost_cnt !== e.cnt) begin
            errors++;
            $display("FAIL lock_lost_cnt t=%0t got %0d want %0d", $time, olock_lost_cnt, e.cnt);
         end
      end
   end

   task automatic cyc(input bit lk, input bit sf);
      @(negedge clk);
      #1;
      ilocked   = lk;
      ireq_soft = sf;
   endtask

   task automatic cycs(input int num, input bit lk);
      for (int i = 0; i < num; i++) cyc(lk, 1'b0);
   endtask

   task automatic do_reset(input bit lk_after);
      @(negedge clk);
      #1;
      irst_n    = 1'b0;
      ireq_soft = 1'b0;
      cycs(3, 1'b0);
      @(negedge clk);
      #1;
      irst_n  = 1'b1;
      ilocked = lk_after;
   endtask

   task automatic chk_async(input string name, input logic [5:0] got, input logic [5:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s t=%0t got %h want %h", name, $time, got, want);
      end
   endtask

   initial begin
      #2_000_000;
      errors++;
      $display("FAIL watchdog t=%0t got timeout want finish", $time);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog expired");
   end

   initial begin
      irst_n    = 1'b0;
      ilocked   = 1'b0;
      ireq_soft = 1'b0;

      // Power-up with lock already good.
      do_reset(1'b1);
      cycs(24, 1'b1);

      // Lock glitch during HOLD restarts the full hold.
      do_reset(1'b1);
      cycs(7, 1'b1);
      cycs(3, 1'b0);
      cycs(24, 1'b1);

      // Lock loss in RUN.
      cycs(2, 1'b0);
      cycs(24, 1'b1);

      // Soft requests in RUN and again during the resulting HOLD.
      cyc(1'b1, 1'b1);
      cycs(4, 1'b1);
      cyc(1'b1, 1'b1);
      cycs(24, 1'b1);

      // Soft request and lock loss reach the FSM on the same edge.
      cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b0);
      cyc(1'b1, 1'b1);
      cycs(24, 1'b1);

      // Saturation of the lock-loss counter.
      for (int i = 0; i < 20; i++) begin
         cycs(20, 1'b1);
         cycs(3, 1'b0);
      end
      cycs(8, 1'b1);

      // Asynchronous reset mid-HOLD, checked between edges.
      @(negedge clk);
      #2;
      irst_n = 1'b0;
      #1;
      chk_async("async_reset", {orst_n, orst, oready, ostate, 1'b0},
                {1'b0, 1'b1, 1'b0, 2'd0, 1'b0});
      checks++;
      if (olock_lost_cnt !== '0) begin
         errors++;
         $display("FAIL async_cnt t=%0t got %0d want 0", $time, olock_lost_cnt);
      end
      cycs(2, 1'b1);
      @(negedge clk);
      #1;
      irst_n = 1'b1;
      cycs(24, 1'b1);

      // Random traffic: mostly locked, occasional drops and soft requests.
      begin
         bit lk;
         lk = 1'b1;
         for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 29) == 0) lk = ~lk;
            cyc(lk, $urandom_range(0, 24) == 0);
         end
      end
      cycs(4, 1'b1);

      @(negedge clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL queue_drain got %0d want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
